lsu_seq: RTL
============

# lsu_seq

Load/store sequencer placed directly upstream of the data memory in the single-cycle processor datapath. Accepts one word (32-bit) or doubleword (64-bit) load/store request at a time from execute and drives the memory's enable, read/write, address and write-data inputs. Splits doubleword accesses into two 32-bit memory beats and reassembles 32-bit read beats into a 64-bit, sign- or zero-extended load result with a single-cycle response pulse.

## Interface
- ADDR_W, 64, address width; memory address and request address are both ADDR_W bits.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_dword  input  1  1 = 64-bit access, 0 = 32-bit access.
- req_signed  input  1  word loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  64  store data; word stores use bits [31:0].
- mem_en  output  1  memory enable, one cycle per beat.
- mem_rw  output  1  1 = write, 0 = read.
- mem_addr  output  ADDR_W  beat address.
- mem_wdata  output  64  beat write data, upper 32 bits always 0.
- mem_rdata  input  32  memory read data, valid the cycle after a read beat is issued.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  64  load result; 0 for stores and errors.
- resp_err  output  1  misaligned request, qualified by resp_valid.

## Operation
- States: IDLE, LO, HI, CAP, RESP.
- IDLE: req_ready=1. On req_valid, latch write/dword/signed/addr/wdata at the clock edge. Aligned request → LO. Misaligned request → RESP with err set and no memory beat.
- Alignment: word requires addr[1:0]==0; dword requires addr[2:0]==0.
- LO: mem_en=1, mem_rw=write, mem_addr=base, mem_wdata={32'b0, wdata[31:0]}.
  - dword → HI.
  - word load → CAP.
  - word store → RESP.
- HI: mem_en=1, mem_addr=base+4 (mod 2^ADDR_W), mem_wdata={32'b0, wdata[63:32]}. Load: capture mem_rdata as low half. Load → CAP; store → RESP.
- CAP: mem_en=0; capture mem_rdata as the final beat → RESP.
- Load result:
  - Dword load: {hi beat, lo beat}.
  - Word load: sign-extended or zero-extended 32-bit beat, per the latched req_signed.
- RESP: resp_valid=1, resp_rdata/resp_err driven from registers → IDLE. req_ready=0 in RESP.
- req_valid outside IDLE is ignored, with no queuing. Request inputs may change freely after acceptance.
- Outside LO/HI: mem_en=0, mem_rw=0, mem_addr=0, mem_wdata=0.

## Timing
- Reset (async, immediate): state IDLE, req_ready=1, mem_en=0, mem_rw=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0, internal latches 0.
- Reset asserted mid-operation aborts the access: mem_en falls without waiting for a clock, and no response is produced. An in-flight store may have been partially written.
- Latency is counted from the accepting edge to the resp_valid cycle. All paths below go through LO; dword paths also go through HI.

| Access | States after accept | resp_valid after accept |
|---|---|---|
| Word store | LO, RESP | 2nd cycle |
| Word load | LO, CAP, RESP | 3rd cycle |
| Dword store | LO, HI, RESP | 3rd cycle |
| Dword load | LO, HI, CAP, RESP | 4th cycle |
| Misaligned | RESP | 1st cycle |

- The next request can be accepted at the earliest in the cycle after RESP.
- Read data sampling: the LO read's data is sampled at the end of the following cycle (HI or CAP). The HI read's data is sampled at the end of CAP.
- resp_valid is exactly one cycle wide. resp_rdata/resp_err hold their value until the next RESP.

## Test plan
- Reset: assert rst mid-dword-load (during HI) → mem_en=0 and req_ready=1 immediately; no resp_valid follows; a new request after release completes normally.
- Word store at addr 0x10, wdata 0xFFFF_FFFF_DEAD_BEEF → one beat: mem_en=1, mem_rw=1, mem_addr=0x10, mem_wdata=0x0000_0000_DEAD_BEEF. resp_valid 2 cycles after accept, resp_rdata=0, resp_err=0.
- Dword load at 0x20 with model returning 0x1111_2222 for 0x20 and 0x3333_4444 for 0x24 → read beats at 0x20 then 0x24 on consecutive cycles. resp_rdata=0x3333_4444_1111_2222 in the 4th cycle after accept.
- Word load of 0x8000_0001: signed → 0xFFFF_FFFF_8000_0001; unsigned → 0x0000_0000_8000_0001.
- Misaligned: dword at 0x14 and word at 0x13 → no mem_en. resp_valid next cycle with resp_err=1, resp_rdata=0.
- Boundary: dword store at 0xFFFF_FFFF_FFFF_FFF8 → second beat address 0xFFFF_FFFF_FFFF_FFFC. Holding req_valid high during busy states → exactly one request is accepted per IDLE visit.

Source files
------------

// File: rtl/lsu_seq.sv
// lsu_seq: load/store sequencer in front of the 32-bit data memory.
// Splits dword accesses into two beats and reassembles load results.
module lsu_seq #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_dword,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err
);

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        CAP,
        RESP
    } state_t;

    state_t            state;
    state_t            nstate;

    logic              wr_q;
    logic              dw_q;
    logic              sg_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [31:0]       lo_q;
    logic [63:0]       rdata_q;
    logic              err_q;

    logic              misal;
    logic [63:0]       ld_res;

    assign misal = req_dword ? (req_addr[2:0] != 3'd0)
                             : (req_addr[1:0] != 2'd0);

    assign ld_res = dw_q ? {mem_rdata, lo_q} :
                    sg_q ? {{32{mem_rdata[31]}}, mem_rdata} :
                           {32'd0, mem_rdata};

    // State register; reset aborts any access immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Next-state selection from the latched request kind.
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    nstate = misal ? RESP : LO;
                end
            end
            LO: begin
                if (dw_q) begin
                    nstate = HI;
                end else if (wr_q) begin
                    nstate = RESP;
                end else begin
                    nstate = CAP;
                end
            end
            HI:      nstate = wr_q ? RESP : CAP;
            CAP:     nstate = RESP;
            RESP:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Memory beat and response drive, decoded from the current state.
    always_comb begin
        req_ready  = 1'b0;
        mem_en     = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        unique case (state)
            IDLE: req_ready = 1'b1;
            LO: begin
                mem_en    = 1'b1;
                mem_rw    = wr_q;
                mem_addr  = addr_q;
                mem_wdata = {32'd0, wdata_q[31:0]};
            end
            HI: begin
                mem_en    = 1'b1;
                mem_rw    = wr_q;
                mem_addr  = addr_q + ADDR_W'(4);
                mem_wdata = {32'd0, wdata_q[63:32]};
            end
            RESP:    resp_valid = 1'b1;
            default: ;
        endcase
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    // Request latches, low-beat capture and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            dw_q    <= 1'b0;
            sg_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                wr_q    <= req_write;
                dw_q    <= req_dword;
                sg_q    <= req_signed;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == HI && !wr_q) begin
                lo_q <= mem_rdata;
            end
            // Result only changes on the edge entering RESP so it
            // holds stable between responses.
            if (state != RESP && nstate == RESP) begin
                err_q   <= (state == IDLE);
                rdata_q <= (state == CAP) ? ld_res : 64'd0;
            end
        end
    end

endmodule
